// File: rtl/motion_collision_ctrl.sv
// motion_collision_ctrl: per-frame character motion controller that probes
// the tile map once per edge (L,R,U,D) over a shared req/ack lookup port,
// then updates velocity and position and holds them until the next tick.
//
// Ports:
//   Clk, Reset                 clock, synchronous active-high reset
//   frame_tick                 one-cycle pulse per frame
//   key_left/right/jump        keyboard level inputs
//   map_req, map_x, map_y      lookup request and probe pixel
//   map_ack, map_solid         lookup done, probe pixel is solid
//   character_X, character_Y   centre position
//   stop_at                    {left,right,up,down} blocked flags
//   on_ground, busy            resting on solid tile, sequence running
//   timeout_err                sticky ack timeout (MOTION_ACK_TIMEOUT_EN)
//
// Optional feature macro: MOTION_ACK_TIMEOUT_EN adds a per-query ack
// watchdog and the timeout_err output.

module motion_collision_ctrl #(
    parameter int BALL_W   = 42,
    parameter int BALL_H   = 56,
    parameter int START_X  = 320,
    parameter int START_Y  = 240,
    parameter int STEP_X   = 2,
    parameter int JUMP_V   = 12,
    parameter int GRAVITY  = 1,
    parameter int MAX_FALL = 8,
    parameter int X_MAX    = 639,
`ifdef MOTION_ACK_TIMEOUT_EN
    parameter int Y_MAX    = 479,
    parameter int ACK_TIMEOUT = 15
`else
    parameter int Y_MAX    = 479
`endif
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_jump,
    output logic       map_req,
    output logic [9:0] map_x,
    output logic [9:0] map_y,
    input  logic       map_ack,
    input  logic       map_solid,
    output logic [9:0] character_X,
    output logic [9:0] character_Y,
    output logic [3:0] stop_at,
    output logic       on_ground,
`ifdef MOTION_ACK_TIMEOUT_EN
    output logic       busy,
    output logic       timeout_err
`else
    output logic       busy
`endif
);

    localparam int HW = BALL_W / 2;
    localparam int HH = BALL_H / 2;

    localparam logic signed [10:0] X_LO = 11'(HW);
    localparam logic signed [10:0] X_HI = 11'(X_MAX - HW);
    localparam logic signed [10:0] Y_LO = 11'(HH);
    localparam logic signed [10:0] Y_HI = 11'(Y_MAX - HH);

    typedef enum logic [2:0] {
        IDLE,
        Q_L,
        Q_R,
        Q_U,
        Q_D,
        UPDATE
    } state_t;

    state_t state;
    state_t nxt_state;

    logic signed [7:0] vy;
    logic [3:0]        flags;
    logic              k_l;
    logic              k_r;
    logic              k_j;

    // Flag bit index per edge: 3=L, 2=R, 1=U, 0=D
    logic [1:0] cur_bit;
    logic [1:0] nxt_bit;
    logic [9:0] px [4];
    logic [9:0] py [4];
    logic [3:0] off;

    logic done;
    logic done_flag;

`ifdef MOTION_ACK_TIMEOUT_EN
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    logic [TW-1:0] to_cnt;
    logic          to_hit;
`endif

    // Probe points and off-screen tests from the registered position
    always_comb begin
        px[3] = character_X - 10'(HW + 1);
        py[3] = character_Y;
        px[2] = character_X + 10'(HW + 1);
        py[2] = character_Y;
        px[1] = character_X;
        py[1] = character_Y - 10'(HH + 1);
        px[0] = character_X;
        py[0] = character_Y + 10'(HH + 1);
        off[3] = (character_X == 10'(HW));
        off[2] = ({1'b0, character_X} + 11'(HW)) >= 11'(X_MAX);
        off[1] = (character_Y == 10'(HH));
        off[0] = ({1'b0, character_Y} + 11'(HH)) >= 11'(Y_MAX);
    end

    always_comb begin
        cur_bit   = 2'd3;
        nxt_state = IDLE;
        case (state)
            Q_L: begin
                cur_bit   = 2'd3;
                nxt_state = Q_R;
            end
            Q_R: begin
                cur_bit   = 2'd2;
                nxt_state = Q_U;
            end
            Q_U: begin
                cur_bit   = 2'd1;
                nxt_state = Q_D;
            end
            Q_D: begin
                cur_bit   = 2'd0;
                nxt_state = UPDATE;
            end
            default: begin
                cur_bit   = 2'd3;
                nxt_state = IDLE;
            end
        endcase
        nxt_bit = cur_bit - 2'd1;
    end

    // Query completion: off-screen, ack, or watchdog expiry
    always_comb begin
        done      = 1'b0;
        done_flag = 1'b0;
`ifdef MOTION_ACK_TIMEOUT_EN
        to_hit    = 1'b0;
`endif
        if (state inside {Q_L, Q_R, Q_U, Q_D}) begin
            if (off[cur_bit]) begin
                done      = 1'b1;
                done_flag = 1'b1;
            end else if (map_ack) begin
                done      = 1'b1;
                done_flag = map_solid;
`ifdef MOTION_ACK_TIMEOUT_EN
            end else if (to_cnt == TW'(ACK_TIMEOUT - 1)) begin
                done      = 1'b1;
                done_flag = 1'b1;
                to_hit    = 1'b1;
`endif
            end
        end
    end

    // Motion update computed from the flags collected this frame
    logic signed [10:0] vx;
    logic signed [8:0]  vy_sum;
    logic signed [7:0]  vy_new;
    logic               og_new;
    logic signed [10:0] nx;
    logic signed [10:0] ny;
    logic [9:0]         x_new;
    logic [9:0]         y_new;

    always_comb begin
        vx = '0;
        if (k_r && !k_l && !flags[2]) begin
            vx = 11'(STEP_X);
        end else if (k_l && !k_r && !flags[3]) begin
            vx = -11'(STEP_X);
        end

        vy_sum = $signed({vy[7], vy}) + $signed(9'(GRAVITY));
        og_new = 1'b0;
        if (flags[0] && !vy[7]) begin
            if (k_j) begin
                vy_new = -8'(JUMP_V);
            end else begin
                vy_new = '0;
                og_new = 1'b1;
            end
        end else if (flags[1] && vy[7]) begin
            vy_new = '0;
        end else if (vy_sum > $signed(9'(MAX_FALL))) begin
            vy_new = 8'(MAX_FALL);
        end else begin
            vy_new = vy_sum[7:0];
        end

        nx = $signed({1'b0, character_X}) + vx;
        ny = $signed({1'b0, character_Y})
           + $signed({{3{vy_new[7]}}, vy_new});

        if (nx < X_LO) begin
            x_new = X_LO[9:0];
        end else if (nx > X_HI) begin
            x_new = X_HI[9:0];
        end else begin
            x_new = nx[9:0];
        end

        if (ny < Y_LO) begin
            y_new = Y_LO[9:0];
        end else if (ny > Y_HI) begin
            y_new = Y_HI[9:0];
        end else begin
            y_new = ny[9:0];
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            character_X <= 10'(START_X);
            character_Y <= 10'(START_Y);
            vy          <= '0;
            stop_at     <= '0;
            on_ground   <= 1'b0;
            map_req     <= 1'b0;
            map_x       <= '0;
            map_y       <= '0;
            busy        <= 1'b0;
            flags       <= '0;
            k_l         <= 1'b0;
            k_r         <= 1'b0;
            k_j         <= 1'b0;
`ifdef MOTION_ACK_TIMEOUT_EN
            to_cnt      <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (frame_tick) begin
                        state   <= Q_L;
                        busy    <= 1'b1;
                        flags   <= '0;
                        k_l     <= key_left;
                        k_r     <= key_right;
                        k_j     <= key_jump;
                        map_req <= !off[3];
                        map_x   <= px[3];
                        map_y   <= py[3];
`ifdef MOTION_ACK_TIMEOUT_EN
                        to_cnt  <= '0;
`endif
                    end
                end
                Q_L, Q_R, Q_U, Q_D: begin
                    if (done) begin
                        flags[cur_bit] <= done_flag;
                        state          <= nxt_state;
                        if (state == Q_D) begin
                            map_req <= 1'b0;
                        end else begin
                            map_req <= !off[nxt_bit];
                            map_x   <= px[nxt_bit];
                            map_y   <= py[nxt_bit];
                        end
`ifdef MOTION_ACK_TIMEOUT_EN
                        to_cnt <= '0;
                        if (to_hit) begin
                            timeout_err <= 1'b1;
                        end
`endif
                    end
`ifdef MOTION_ACK_TIMEOUT_EN
                    else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                UPDATE: begin
                    stop_at     <= flags;
                    vy          <= vy_new;
                    on_ground   <= og_new;
                    character_X <= x_new;
                    character_Y <= y_new;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_motion_collision_ctrl.sv
// Directed self-checking bench for motion_collision_ctrl.
// A small tile-map responder answers lookups with programmable ack delay.

module tb_motion_collision_ctrl;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_tick;
    logic       key_left;
    logic       key_right;
    logic       key_jump;
    logic       map_req;
    logic [9:0] map_x;
    logic [9:0] map_y;
    logic       map_ack;
    logic       map_solid;
    logic [9:0] character_X;
    logic [9:0] character_Y;
    logic [3:0] stop_at;
    logic       on_ground;
    logic       busy;
`ifdef MOTION_ACK_TIMEOUT_EN
    logic       timeout_err;
`endif

    motion_collision_ctrl dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_tick  (frame_tick),
        .key_left    (key_left),
        .key_right   (key_right),
        .key_jump    (key_jump),
        .map_req     (map_req),
        .map_x       (map_x),
        .map_y       (map_y),
        .map_ack     (map_ack),
        .map_solid   (map_solid),
        .character_X (character_X),
        .character_Y (character_Y),
        .stop_at     (stop_at),
        .on_ground   (on_ground),
`ifdef MOTION_ACK_TIMEOUT_EN
        .busy        (busy),
        .timeout_err (timeout_err)
`else
        .busy        (busy)
`endif
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Responder controls: ack_delay >= 100 means never ack
    int ack_delay = 0;
    int ack_cnt   = 0;
    int sx = 1023;
    int sy = 1023;
    int srow = 1023;

    logic       prev_req = 1'b0;
    logic       prev_ack = 1'b0;
    logic [9:0] prev_x = '0;
    logic [9:0] prev_y = '0;
    int         unstable = 0;

    int         busy_cnt;
    int         cyc_n;
    logic       first_req;
    logic [9:0] first_x;
    logic [9:0] first_y;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic respond();
        if (map_req && prev_req && !prev_ack &&
            (map_x !== prev_x || map_y !== prev_y))
            unstable++;
        if (map_req) begin
            map_ack = (ack_delay < 100) && (ack_cnt == ack_delay);
            ack_cnt = map_ack ? 0 : ack_cnt + 1;
        end else begin
            map_ack = (ack_delay == 0);
            ack_cnt = 0;
        end
        map_solid = ((int'(map_x) == sx) && (int'(map_y) == sy)) ||
                    (int'(map_y) == srow);
        prev_req = map_req;
        prev_ack = map_ack;
        prev_x   = map_x;
        prev_y   = map_y;
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
        respond();
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        frame_tick = 1'b0;
        cyc();
        cyc();
        Reset = 1'b0;
        cyc();
    endtask

    // Pulse a tick, then count busy cycles; ends on the first idle cycle
    task automatic run_frame();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        first_req = map_req;
        first_x   = map_x;
        first_y   = map_y;
        busy_cnt  = 0;
        while (busy && busy_cnt < 200) begin
            busy_cnt++;
            cyc();
        end
    endtask

    initial begin
        Reset = 1'b1;
        frame_tick = 1'b0;
        key_left = 1'b0;
        key_right = 1'b0;
        key_jump = 1'b0;
        map_ack = 1'b1;
        map_solid = 1'b0;

        // Reset state
        do_reset();
        check("rst_x", 32'(character_X), 320);
        check("rst_y", 32'(character_Y), 240);
        check("rst_stop", 32'(stop_at), 0);
        check("rst_og", 32'(on_ground), 0);
        check("rst_req", 32'(map_req), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_mapx", 32'(map_x), 0);
        check("rst_mapy", 32'(map_y), 0);

        // Free fall, latency
        run_frame();
        check("t1_busy_cycles", 32'(busy_cnt), 5);
        check("t1_first_req", 32'(first_req), 1);
        check("t1_probe_lx", 32'(first_x), 298);
        check("t1_probe_ly", 32'(first_y), 240);
        check("t1_x", 32'(character_X), 320);
        check("t1_y", 32'(character_Y), 241);
        check("t1_stop", 32'(stop_at), 0);
        check("t1_og", 32'(on_ground), 0);
        run_frame();
        check("t1_y2", 32'(character_Y), 243);

        // Right wall blocks walking
        do_reset();
        key_right = 1'b1;
        sx = 342;
        sy = 240;
        run_frame();
        check("t2_stop", 32'(stop_at), 32'b0100);
        check("t2_x_blocked", 32'(character_X), 320);
        check("t2_y", 32'(character_Y), 241);
        sx = 1023;
        sy = 1023;
        run_frame();
        check("t2_stop_free", 32'(stop_at), 0);
        check("t2_x_walk", 32'(character_X), 322);
        check("t2_y2", 32'(character_Y), 243);
        key_right = 1'b0;

        // Standing on floor without jump
        do_reset();
        srow = 269;
        run_frame();
        check("t3_stand_stop", 32'(stop_at), 32'b0001);
        check("t3_stand_og", 32'(on_ground), 1);
        check("t3_stand_y", 32'(character_Y), 240);

        // Jump off floor, then rise
        do_reset();
        key_jump = 1'b1;
        run_frame();
        check("t3_jump_og", 32'(on_ground), 0);
        check("t3_jump_y", 32'(character_Y), 228);
        check("t3_jump_stop", 32'(stop_at), 32'b0001);
        key_jump = 1'b0;
        srow = 1023;
        run_frame();
        check("t3_rise_y", 32'(character_Y), 217);
        check("t3_rise_og", 32'(on_ground), 0);

        // Jump into a ceiling kills the upward speed
        do_reset();
        srow = 269;
        key_jump = 1'b1;
        run_frame();
        key_jump = 1'b0;
        srow = 199;
        run_frame();
        check("t3_ceil_stop", 32'(stop_at), 32'b0010);
        check("t3_ceil_y", 32'(character_Y), 228);
        srow = 1023;
        run_frame();
        check("t3_after_ceil_y", 32'(character_Y), 229);

        // Walk to the left screen edge
        do_reset();
        key_left = 1'b1;
        for (int i = 0; i < 150; i++) run_frame();
        check("t4_x_clamp", 32'(character_X), 21);
        run_frame();
        check("t4_no_l_req", 32'(first_req), 0);
        check("t4_busy_cycles", 32'(busy_cnt), 5);
        check("t4_stop", 32'(stop_at), 32'b1001);
        check("t4_x", 32'(character_X), 21);
        check("t4_y_floor", 32'(character_Y), 451);
        check("t4_og", 32'(on_ground), 1);
        key_left = 1'b0;

        // Delayed ack and an ignored tick in cycle 8
        do_reset();
        ack_delay = 3;
        unstable = 0;
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        check("t5_req_c1", 32'(map_req), 1);
        check("t5_probe_lx", 32'(map_x), 298);
        busy_cnt = 0;
        cyc_n = 1;
        while (busy && busy_cnt < 200) begin
            frame_tick = (cyc_n == 8);
            busy_cnt++;
            cyc();
            cyc_n++;
        end
        frame_tick = 1'b0;
        check("t5_busy_cycles", 32'(busy_cnt), 17);
        check("t5_stable", 32'(unstable), 0);
        check("t5_x", 32'(character_X), 320);
        check("t5_y", 32'(character_Y), 241);
        busy_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (busy) busy_cnt++;
            cyc();
        end
        check("t5_no_requeue", 32'(busy_cnt), 0);

        // Reset in the middle of a sequence
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        cyc();
        check("t6_req_mid", 32'(map_req), 1);
        Reset = 1'b1;
        cyc();
        Reset = 1'b0;
        check("t6_req_drop", 32'(map_req), 0);
        check("t6_busy_drop", 32'(busy), 0);
        check("t6_y_reset", 32'(character_Y), 240);
        ack_delay = 0;
        cyc();

`ifdef MOTION_ACK_TIMEOUT_EN
        do_reset();
        check("t7_err_rst", 32'(timeout_err), 0);
        ack_delay = 1000;
        run_frame();
        check("t7_busy_cycles", 32'(busy_cnt), 61);
        check("t7_stop", 32'(stop_at), 32'b1111);
        check("t7_err", 32'(timeout_err), 1);
        check("t7_og", 32'(on_ground), 1);
        ack_delay = 0;
        do_reset();
        check("t7_err_clr", 32'(timeout_err), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
